// File: rtl/mux_n_reg_if.sv
// mux_n_reg_if: handshake bundle for mux_n_reg.
// The upstream producers and downstream consumer sit on the master side.
// The mux itself sits on the slave side.
interface mux_n_reg_if #(
  parameter int W    = 5,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_n_reg.sv
// mux_n_reg: N-channel, W-bit multiplexer with a one-word output register.
// Every input and the output use a valid/ready handshake.
// Defining MUX_N_REG_RR_EN replaces the external sel with a round-robin
// arbiter over the valid channels. The default build uses sel directly.
module mux_n_reg #(
  parameter int W    = 5,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input logic        clk,
  input logic        rst,
  mux_n_reg_if.slave bus
);

  logic [W-1:0]    data_q;
  logic [SELW-1:0] ch_q;
  logic            valid_q;

  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic            can_load;
  logic [N-1:0]    ready_vec;
  logic [W-1:0]    word;
  logic            accept;

  // The register can take a new word when empty or while its word leaves.
  assign can_load = !valid_q | bus.out_ready;

  // Steer the granted channel's word and raise only that channel's ready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word      = '0;
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vld && int'(grant) == i) begin
        word         = bus.in_data[i*W +: W];
        ready_vec[i] = can_load;
      end
    end
  end

  assign accept       = |(ready_vec & bus.in_valid);
  assign bus.in_ready = ready_vec;

  // Load on accept (also covers pop+accept), drop valid on a bare pop.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= word;
      ch_q    <= grant;
      valid_q <= 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

`ifdef MUX_N_REG_RR_EN
  logic [SELW-1:0] rr_ptr;
  logic [N-1:0]    rot;

  // Rotate the valids so bit 0 is the channel right after the last winner.
  // When rr_ptr+1 equals N, the shift by N is the same as no rotation.
  assign rot = N'({bus.in_valid, bus.in_valid} >> (rr_ptr + SELW'(1)));

  // Grant the nearest valid channel after rr_ptr, cyclically.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        grant_vld = 1'b1;
        grant     = SELW'((int'(rr_ptr) + 1 + j) % N);
      end
    end
  end

  // Remember the last winner; it gets lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SELW'(N - 1);
    end else if (accept) begin
      rr_ptr <= grant;
    end
  end
`else
  // Fixed select: a value of N or more selects nothing.
  always_comb begin
    grant     = bus.sel;
    grant_vld = (int'(bus.sel) < N);
  end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed bench for mux_n_reg.
// A behavioural model is checked on every falling edge.
// Hand-computed literal checks pin the key points of the scenario.
module tb_mux_n_reg;
  localparam int W    = 5;
  localparam int N    = 4;
  localparam int SELW = 2;

  logic clk;
  logic rst;
  int   checks  = 0;
  int   errors  = 0;
  bit   run_cmp = 0;

  int rr_seq_a[5] = '{0, 1, 2, 3, 0};
  int rr_seq_b[3] = '{2, 3, 0};
  int word_of[4]  = '{3, 5, 7, 9};

  mux_n_reg_if #(.W(W), .N(N), .SELW(SELW)) bus4 ();
  mux_n_reg_if #(.W(W), .N(3), .SELW(SELW)) bus3 ();

  mux_n_reg #(.W(W), .N(N), .SELW(SELW)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_n_reg #(.W(W), .N(3), .SELW(SELW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 4-channel instance ----------------
  int m_valid, m_data, m_ch, m_ptr;

  function automatic int model_grant();
`ifdef MUX_N_REG_RR_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (((int'(bus4.in_valid) >> c) & 1) != 0) return c;
    end
    return -1;
`else
    if (int'(bus4.sel) < N) return int'(bus4.sel);
    return -1;
`endif
  endfunction

  function automatic bit model_can_load();
    return (m_valid == 0) || (bus4.out_ready == 1'b1);
  endfunction

  function automatic int model_ready();
    int g;
    g = model_grant();
    if (g < 0 || !model_can_load()) return 0;
    return 1 << g;
  endfunction

  function automatic bit model_accept();
    int g;
    g = model_grant();
    if (g < 0 || !model_can_load()) return 1'b0;
    return ((int'(bus4.in_valid) >> g) & 1) != 0;
  endfunction

  function automatic int model_word();
    int g;
    g = model_grant();
    return (int'(bus4.in_data) >> (g * W)) & 31;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0;
      m_data  <= 0;
      m_ch    <= 0;
      m_ptr   <= N - 1;
    end else if (model_accept()) begin
      m_valid <= 1;
      m_data  <= model_word();
      m_ch    <= model_grant();
      m_ptr   <= model_grant();
    end else if (m_valid != 0 && bus4.out_ready) begin
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      check("cmp out_valid", 32'(bus4.out_valid), m_valid);
      check("cmp out_data",  32'(bus4.out_data),  m_data);
      check("cmp out_ch",    32'(bus4.out_ch),    m_ch);
      check("cmp in_ready",  32'(bus4.in_ready),  model_ready());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus4.in_data   = '0;
    bus4.in_valid  = '0;
    bus4.sel       = '0;
    bus4.out_ready = 1'b0;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.sel       = 2'd3;
    bus3.out_ready = 1'b0;
    #3;
    check("reset out_valid", 32'(bus4.out_valid), 0);
    check("reset out_data",  32'(bus4.out_data),  0);
    check("reset out_ch",    32'(bus4.out_ch),    0);
`ifdef MUX_N_REG_RR_EN
    check("reset in_ready",  32'(bus4.in_ready),  0);
`else
    check("reset in_ready",  32'(bus4.in_ready),  1);
`endif
    tick();
    rst     = 1'b0;
    run_cmp = 1'b1;

`ifndef MUX_N_REG_RR_EN
    // Channel change under fixed select.
    bus4.in_data   = {5'd9, 5'd7, 5'd5, 5'd3};
    bus4.in_valid  = 4'hF;
    bus4.sel       = 2'd0;
    bus4.out_ready = 1'b1;
    tick();
    check("ch0 out_valid", 32'(bus4.out_valid), 1);
    check("ch0 out_data",  32'(bus4.out_data),  3);
    check("ch0 out_ch",    32'(bus4.out_ch),    0);
    bus4.sel = 2'd2;
    #1;
    check("sel2 in_ready", 32'(bus4.in_ready), 4'b0100);
    tick();
    check("ch2 out_data", 32'(bus4.out_data), 7);
    check("ch2 out_ch",   32'(bus4.out_ch),   2);

    // Stall for three cycles, then resume with a new word on channel 2.
    bus4.out_ready      = 1'b0;
    bus4.in_data[14:10] = 5'd17;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall out_data",  32'(bus4.out_data),  7);
      check("stall out_valid", 32'(bus4.out_valid), 1);
      check("stall in_ready",  32'(bus4.in_ready),  0);
    end
    bus4.out_ready = 1'b1;
    #1;
    check("resume in_ready", 32'(bus4.in_ready), 4'b0100);
    tick();
    check("b2b out_valid", 32'(bus4.out_valid), 1);
    check("b2b out_data",  32'(bus4.out_data),  17);
    bus4.in_data[14:10] = 5'd21;
    tick();
    check("b2b2 out_data", 32'(bus4.out_data), 21);

    // Highest in-range select.
    bus4.sel = 2'd3;
    tick();
    check("ch3 out_data", 32'(bus4.out_data), 9);
    check("ch3 out_ch",   32'(bus4.out_ch),   3);

    // Pop with no new input, then out_ready on an empty register.
    bus4.in_valid = 4'h0;
    tick();
    check("pop out_valid", 32'(bus4.out_valid), 0);
    check("pop out_data",  32'(bus4.out_data),  9);
    check("pop out_ch",    32'(bus4.out_ch),    3);
    tick();
    check("idle out_valid", 32'(bus4.out_valid), 0);

    // Asynchronous reset in the middle of a stall.
    bus4.in_data[14:10] = 5'h1F;
    bus4.in_valid       = 4'b0100;
    bus4.sel            = 2'd2;
    bus4.out_ready      = 1'b0;
    tick();
    check("load 1F out_data", 32'(bus4.out_data), 5'h1F);
    bus4.in_valid = 4'h0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus4.out_valid), 0);
    check("async rst out_data",  32'(bus4.out_data),  0);
    check("async rst out_ch",    32'(bus4.out_ch),    0);
    tick();
    rst = 1'b0;

    // Out-of-range select on the 3-channel instance.
    bus3.in_data   = {5'd4, 5'd2, 5'd1};
    bus3.in_valid  = 3'b111;
    bus3.sel       = 2'd3;
    bus3.out_ready = 1'b1;
    #1;
    check("oor in_ready", 32'(bus3.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("oor out_valid", 32'(bus3.out_valid), 0);
    end
    bus3.sel = 2'd1;
    #1;
    check("n3 sel1 in_ready", 32'(bus3.in_ready), 3'b010);
    tick();
    check("n3 ch1 out_data", 32'(bus3.out_data), 2);
    check("n3 ch1 out_ch",   32'(bus3.out_ch),   1);
    bus3.sel = 2'd2;
    tick();
    check("n3 ch2 out_data", 32'(bus3.out_data), 4);
    check("n3 ch2 out_ch",   32'(bus3.out_ch),   2);
`else
    // Round-robin over all four channels, starting after rr_ptr = N-1.
    bus4.in_data   = {5'd9, 5'd7, 5'd5, 5'd3};
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    foreach (rr_seq_a[i]) begin
      tick();
      check("rr all out_ch",   32'(bus4.out_ch),   rr_seq_a[i]);
      check("rr all out_data", 32'(bus4.out_data), word_of[rr_seq_a[i]]);
    end
    // Channel 1 drops out and is skipped.
    bus4.in_valid = 4'b1101;
    foreach (rr_seq_b[i]) begin
      tick();
      check("rr skip out_ch", 32'(bus4.out_ch), rr_seq_b[i]);
    end
    // Single requester wins every cycle.
    bus4.in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr solo out_ch",    32'(bus4.out_ch),    3);
      check("rr solo out_valid", 32'(bus4.out_valid), 1);
    end
    // Pointer wraps, so channel 0 wins over channel 3.
    bus4.in_valid = 4'b1001;
    tick();
    check("rr wrap out_ch",   32'(bus4.out_ch),   0);
    check("rr wrap out_data", 32'(bus4.out_data), 3);
`endif

    tick();
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
